serial_subtract_ctrl: RTL and testbench
=======================================

Name: serial_subtract_ctrl

Overview:
- Bit-serial subtraction controller that time-multiplexes a single 1-bit subtract cell over a WIDTH-bit operand pair.
- The cell is two cascaded half subtractors with a registered borrow.
- Computes diff = a - b (unsigned, modulo 2^WIDTH) plus a final borrow flag, one bit per clock, LSB first.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  controller can accept operands (IDLE only).
- a_i  input  WIDTH  minuend, sampled on accept.
- b_i  input  WIDTH  subtrahend, sampled on accept.
- out_valid_o  output  1  result valid (DONE state).
- out_ready_i  input  1  consumer accepts result.
- diff_o  output  WIDTH  difference a - b mod 2^WIDTH.
- borrow_o  output  1  final borrow; 1 iff a < b unsigned.
- busy_o  output  1  high in RUN or DONE.

Behaviour:
- Reset (reset=1 at a clk edge):
  - State goes to IDLE; bit counter, borrow register and operand/result shift registers clear to 0.
  - Outputs: in_ready_o=1, out_valid_o=0, diff_o=0, borrow_o=0, busy_o=0.
  - Reset wins over every other input in the same cycle.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i=1 at an edge: capture a_i/b_i, clear borrow, clear counter, go to RUN.
  - in_valid_i=0: stay in IDLE.
- RUN:
  - in_ready_o=0; in_valid_i and a_i/b_i are ignored.
  - Each cycle processes bit k = counter, with br the borrow register:
    - d = a[k] ^ b[k] ^ br
    - br_next = (~a[k] & b[k]) | (~(a[k] ^ b[k]) & br)
  - d shifts into the result register at the MSB (shift right), so after WIDTH shifts bit 0 sits at the LSB.
  - Counter increments 0..WIDTH-1. On the edge that processes bit WIDTH-1, go to DONE.
  - On that same edge, load diff_o from the full result and borrow_o from br_next.
- DONE:
  - out_valid_o=1. diff_o and borrow_o stay stable while out_valid_o=1 and out_ready_i=0 (backpressure; no timeout).
  - On out_ready_i=1: go to IDLE, drop out_valid_o.
  - A new operand is not accepted in the same cycle; in_ready_o rises the cycle after the handoff.
- Latency:
  - Accept edge E0 → out_valid_o high after edge E0+WIDTH.
  - Minimum throughput: one result per WIDTH+2 cycles.
- diff_o and borrow_o hold the last completed result through IDLE and RUN. They change only on the RUN→DONE edge or on reset.
- WIDTH=1: RUN lasts exactly one cycle. Counter is sized $clog2(WIDTH+1) and must not wrap before the terminal compare.
- Reset mid-RUN or mid-DONE:
  - Aborts immediately to IDLE with reset values.
  - No out_valid_o pulse is produced for the aborted operation.
- busy_o = (state != IDLE).

Test Plan:
- Reset: hold reset 3 cycles with in_valid_i=1 → in_ready_o=1, out_valid_o=0, diff_o=0, borrow_o=0, busy_o=0, and no accept.
- WIDTH=8, a=25, b=10, out_ready_i=1 → out_valid_o rises exactly 8 edges after accept; diff_o=15, borrow_o=0.
- a=10, b=25 → diff_o=8'hF1, borrow_o=1.
- Corner operands:
  - a=0, b=0 → diff_o=0, borrow_o=0.
  - a=8'h00, b=8'h01 → diff_o=8'hFF, borrow_o=1.
  - a=8'hFF, b=8'hFF → diff_o=0, borrow_o=0.
- Backpressure and ignore: hold out_ready_i=0 for 5 cycles in DONE → out_valid_o and diff_o stable. Toggle in_valid_i with new operands during RUN and DONE → ignored. Release out_ready_i → IDLE next edge, and in_ready_o=1.
- Reset and exhaustive sweep:
  - Assert reset at RUN bit 4 (a=200, b=7) → IDLE next edge, no out_valid_o pulse. A following op a=7, b=200 yields diff_o=8'h3F, borrow_o=1.
  - WIDTH=1 build: all four (a,b) combinations → diff/borrow = 0/0, 1/1, 1/0, 0/0, each valid 1 edge after accept.

Source files
------------

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: one 1-bit subtract cell (two cascaded half
// subtractors + registered borrow) time-multiplexed over a WIDTH-bit operand pair.
module serial_subtract_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             hs1_d_c, hs1_b_c;
    logic             hs2_d_c, hs2_b_c;
    logic             br_next_c;

    // Subtract cell: operands are shifted right, so the current bit is always at [0]
    always_comb begin
        hs1_d_c   = a_q[0] ^ b_q[0];
        hs1_b_c   = ~a_q[0] & b_q[0];
        hs2_d_c   = hs1_d_c ^ br_q;
        hs2_b_c   = ~hs1_d_c & br_q;
        br_next_c = hs1_b_c | hs2_b_c;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next_c;
                res_d = WIDTH'({hs2_d_c, res_q} >> 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_d;
                    borrow_d = br_next_c;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Handshake flags decode directly from the state register
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: an 8-bit instance plus a 1-bit
// instance, checked against an arithmetic subtraction model.
module tb_serial_subtract_ctrl;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, borrow, busy;
    logic [W-1:0] a, b, diff;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, borrow1, busy1;
    logic [0:0]   a1, b1, diff1;

    int checks   = 0;
    int failures = 0;

    serial_subtract_ctrl #(.WIDTH(W)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .diff_o(diff), .borrow_o(borrow), .busy_o(busy)
    );

    serial_subtract_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .diff_o(diff1), .borrow_o(borrow1), .busy_o(busy1)
    );

    // Reference: modular difference and unsigned-less-than borrow
    function automatic void model(input longint unsigned x, input longint unsigned y,
                                  input int unsigned w,
                                  output longint unsigned d, output bit br);
        longint unsigned m;
        m  = 64'(1) << w;
        d  = (x + m - y) % m;
        br = (x < y);
    endfunction

    // Accept one operand pair and wait (bounded) for DONE; optional input noise during RUN
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise,
                          output int lat, output bit held);
        logic [W-1:0] d0;
        d0        = diff;
        held      = 1'b1;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        if (diff !== d0) held = 1'b0;
        while (out_valid !== 1'b1 && lat < 4 * W + 8) begin
            if (noise) begin
                in_valid = 1'($urandom);
                a        = W'($urandom);
                b        = W'($urandom);
            end
            @(negedge clk);
            lat++;
            if (out_valid !== 1'b1 && diff !== d0) held = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_valid1 = 1'b1;
        a         = 8'd55;
        b         = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, diff, borrow, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset8 got rdy=%b vld=%b diff=%h br=%b busy=%b exp 1 0 00 0 0",
                     in_ready, out_valid, diff, borrow, busy);
        end
        checks++;
        if ({in_ready1, out_valid1, diff1, borrow1, busy1} !== 5'b10000) begin
            failures++;
            $display("FAIL reset1 got %b%b%b%b%b exp 10000",
                     in_ready1, out_valid1, diff1, borrow1, busy1);
        end
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept got rdy=%b busy=%b exp 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [5] = '{8'd25, 8'd10, 8'd0, 8'h00, 8'hFF};
        logic [W-1:0] ys [5] = '{8'd10, 8'd25, 8'd0, 8'h01, 8'hFF};
        longint unsigned ed;
        bit eb, held;
        int lat;
        for (int i = 0; i < 5; i++) begin
            model(64'(xs[i]), 64'(ys[i]), W, ed, eb);
            run_op(xs[i], ys[i], 1'b0, lat, held);
            checks++;
            if (lat != W) begin
                failures++;
                $display("FAIL dir_latency a=%0d b=%0d got=%0d exp=%0d", xs[i], ys[i], lat, W);
            end
            checks++;
            if (diff !== W'(ed) || borrow !== eb) begin
                failures++;
                $display("FAIL dir_result a=%0d b=%0d got diff=%h br=%b exp diff=%h br=%b",
                         xs[i], ys[i], diff, borrow, W'(ed), eb);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir_handoff got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        longint unsigned ed;
        bit eb, held;
        int lat;
        for (int i = 0; i < 20; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            model(64'(x), 64'(y), W, ed, eb);
            run_op(x, y, 1'b1, lat, held);
            checks++;
            if (lat != W || held !== 1'b1) begin
                failures++;
                $display("FAIL rnd_timing a=%0d b=%0d got lat=%0d held=%b exp lat=%0d held=1",
                         x, y, lat, held, W);
            end
            checks++;
            if (diff !== W'(ed) || borrow !== eb) begin
                failures++;
                $display("FAIL rnd_result a=%0d b=%0d got diff=%h br=%b exp diff=%h br=%b",
                         x, y, diff, borrow, W'(ed), eb);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        longint unsigned ed;
        bit eb, held;
        int lat;
        model(64'd77, 64'd150, W, ed, eb);
        run_op(8'd77, 8'd150, 1'b1, lat, held);
        checks++;
        if (lat != W || diff !== W'(ed) || borrow !== eb) begin
            failures++;
            $display("FAIL bp_result got lat=%0d diff=%h br=%b exp lat=%0d diff=%h br=%b",
                     lat, diff, borrow, W, W'(ed), eb);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== W'(ed) || borrow !== eb) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b diff=%h br=%b exp 1 0 %h %b",
                         i, out_valid, in_ready, diff, borrow, W'(ed), eb);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || diff !== W'(ed)) begin
            failures++;
            $display("FAIL bp_release got vld=%b rdy=%b busy=%b diff=%h exp 0 1 0 %h",
                     out_valid, in_ready, busy, diff, W'(ed));
        end
    endtask

    task automatic test_reset_abort();
        bit seen, held;
        int lat;
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, diff, borrow, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_state got rdy=%b vld=%b diff=%h br=%b busy=%b exp 1 0 00 0 0",
                     in_ready, out_valid, diff, borrow, busy);
        end
        reset = 1'b0;
        seen  = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_valid got pulse=%b exp 0", seen);
        end
        run_op(8'd7, 8'd200, 1'b0, lat, held);
        checks++;
        if (lat != W || diff !== 8'h3F || borrow !== 1'b1) begin
            failures++;
            $display("FAIL abort_followup got lat=%0d diff=%h br=%b exp lat=%0d diff=3f br=1",
                     lat, diff, borrow, W);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_width1();
        longint unsigned ed;
        bit eb;
        int lat;
        for (int i = 0; i < 4; i++) begin
            model(64'(i >> 1), 64'(i & 1), 1, ed, eb);
            in_valid1  = 1'b1;
            a1         = 1'(i >> 1);
            b1         = 1'(i);
            out_ready1 = 1'b0;
            @(negedge clk);
            in_valid1 = 1'b0;
            lat       = 0;
            while (out_valid1 !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != 1 || diff1 !== 1'(ed) || borrow1 !== eb) begin
                failures++;
                $display("FAIL w1 a=%0d b=%0d got lat=%0d diff=%b br=%b exp lat=1 diff=%b br=%b",
                         i >> 1, i & 1, lat, diff1, borrow1, 1'(ed), eb);
            end
            out_ready1 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
